// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a RUN/HALTED FSM.
// Redirects override stalls; a halt freezes fetch until reset.
module fetch_unit #(
   parameter int PC_W = 9
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            Stall,
   input  logic            PcSel,
   input  logic [31:0]     BrPC,
   input  logic            Halt,
   input  logic [31:0]     Instr_in,
   output logic [PC_W-1:0] Fetch_PC,
   output logic [PC_W-1:0] IF_PC,
   output logic [31:0]     IF_Instr,
   output logic            IF_Valid,
   output logic            Flush_ID,
   output logic            Halted,
   output logic            Misalign_Err,
   output logic [15:0]     Redirect_Cnt
);

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

   localparam logic [PC_W-1:0] PC_STEP = {{(PC_W-3){1'b0}}, 3'b100};

   logic [0:0]      state_q,    state_d;
   logic [PC_W-1:0] pc_q,       pc_d;
   logic [PC_W-1:0] if_pc_q,    if_pc_d;
   logic [31:0]     if_instr_q, if_instr_d;
   logic            if_valid_q, if_valid_d;
   logic            misalign_q, misalign_d;
   logic [15:0]     cnt_q,      cnt_d;

   // Next-state decode; priority inside RUN is Halt, then PcSel, then Stall.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      if_valid_d = if_valid_q;
      misalign_d = misalign_q;
      cnt_d      = cnt_q;
      case (state_q)
         ST_RUN: begin
            if (Halt) begin
               state_d    = ST_HALTED;
               if_valid_d = 1'b0;
            end else if (PcSel) begin
               pc_d       = {BrPC[PC_W-1:2], 2'b00};
               if_valid_d = 1'b0;
               misalign_d = misalign_q | (BrPC[1:0] != 2'b00);
               if (cnt_q != 16'hFFFF) begin
                  cnt_d = cnt_q + 16'd1;
               end else begin
                  cnt_d = cnt_q;
               end
            end else if (Stall) begin
               pc_d       = pc_q;
               if_valid_d = if_valid_q;
            end else begin
               pc_d       = pc_q + PC_STEP;
               if_pc_d    = pc_q;
               if_instr_d = Instr_in;
               if_valid_d = 1'b1;
            end
         end
         ST_HALTED: begin
            if_valid_d = 1'b0;
         end
         default: begin
            state_d    = ST_RUN;
            if_valid_d = 1'b0;
         end
      endcase
   end

   // Pipeline state registers with asynchronous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_RUN;
         pc_q       <= {PC_W{1'b0}};
         if_pc_q    <= {PC_W{1'b0}};
         if_instr_q <= 32'h0000_0000;
         if_valid_q <= 1'b0;
         misalign_q <= 1'b0;
         cnt_q      <= 16'h0000;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         if_valid_q <= if_valid_d;
         misalign_q <= misalign_d;
         cnt_q      <= cnt_d;
      end
   end

   assign Fetch_PC     = pc_q;
   assign IF_PC        = if_pc_q;
   assign IF_Instr     = if_instr_q;
   assign IF_Valid     = if_valid_q;
   assign Misalign_Err = misalign_q;
   assign Redirect_Cnt = cnt_q;
   assign Halted       = (state_q == ST_HALTED);
   // The ID/EX kill must act in the same cycle the branch unit asks for it.
   assign Flush_ID     = (state_q == ST_RUN) && (PcSel || Halt);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a reference model predicts each edge's outcome,
// the prediction is queued at drive time and popped after the edge.
module tb_fetch_unit;

   logic        clk;
   logic        reset_n;
   logic        Stall;
   logic        PcSel;
   logic [31:0] BrPC;
   logic        Halt;
   logic [31:0] Instr_in;
   logic [8:0]  Fetch_PC;
   logic [8:0]  IF_PC;
   logic [31:0] IF_Instr;
   logic        IF_Valid;
   logic        Flush_ID;
   logic        Halted;
   logic        Misalign_Err;
   logic [15:0] Redirect_Cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [8:0]  pc;
      logic [8:0]  if_pc;
      logic [31:0] if_instr;
      logic        if_valid;
      logic        halted;
      logic        mis;
      logic [15:0] cnt;
      logic        flush;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   logic obs_flush;

   logic [8:0]  m_pc;
   logic [8:0]  m_if_pc;
   logic [31:0] m_if_instr;
   logic        m_valid;
   logic        m_halted;
   logic        m_mis;
   logic [15:0] m_cnt;

   fetch_unit #(.PC_W(9)) dut (
      .clk(clk), .reset_n(reset_n), .Stall(Stall), .PcSel(PcSel), .BrPC(BrPC),
      .Halt(Halt), .Instr_in(Instr_in), .Fetch_PC(Fetch_PC), .IF_PC(IF_PC),
      .IF_Instr(IF_Instr), .IF_Valid(IF_Valid), .Flush_ID(Flush_ID), .Halted(Halted),
      .Misalign_Err(Misalign_Err), .Redirect_Cnt(Redirect_Cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [8:0] pc);
      return {16'hC0DE, 7'h00, pc};
   endfunction

   assign Instr_in = instr_of(Fetch_PC);

   task automatic model_reset();
      m_pc = 9'h000; m_if_pc = 9'h000; m_if_instr = 32'h0; m_valid = 1'b0;
      m_halted = 1'b0; m_mis = 1'b0; m_cnt = 16'h0000;
   endtask

   // Apply one cycle of inputs, predict the edge, queue the prediction.
   task automatic drive(input logic st, input logic ps, input logic [31:0] br, input logic ht);
      exp_t x;
      @(negedge clk);
      Stall = st; PcSel = ps; BrPC = br; Halt = ht;
      #1;
      obs_flush = Flush_ID;
      x.flush = !m_halted && (ps || ht);
      if (!m_halted) begin
         if (ht) begin
            m_halted = 1'b1; m_valid = 1'b0;
         end else if (ps) begin
            m_pc = br[8:0] & 9'h1FC;
            m_valid = 1'b0;
            if (br[1:0] != 2'b00) m_mis = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         end else if (!st) begin
            m_if_pc = m_pc; m_if_instr = instr_of(m_pc); m_valid = 1'b1;
            m_pc = m_pc + 9'd4;
         end
      end
      x.pc = m_pc; x.if_pc = m_if_pc; x.if_instr = m_if_instr; x.if_valid = m_valid;
      x.halted = m_halted; x.mis = m_mis; x.cnt = m_cnt;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      #2;
      reset_n = 1'b0;
      Stall = 1'b0; PcSel = 1'b0; BrPC = 32'h0; Halt = 1'b0;
      #1;
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      Stall = 1'b0; PcSel = 1'b0; BrPC = 32'h0; Halt = 1'b0;
      model_reset();
      @(posedge clk); #1;
      reset_n = 1'b1;
      drive(1'b0, 1'b1, 32'h0000_0123, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      void'(sb.pop_front()); void'(sb.pop_front());
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({Fetch_PC, IF_PC, IF_Instr, IF_Valid, Misalign_Err, Redirect_Cnt, Halted} !== 77'h0) begin
         failures++;
         $display("FAIL reset_async pc=%h if_pc=%h instr=%h v=%b mis=%b cnt=%h halted=%b required all zero",
                  Fetch_PC, IF_PC, IF_Instr, IF_Valid, Misalign_Err, Redirect_Cnt, Halted);
      end
      model_reset();
      @(posedge clk); #1;
      reset_n = 1'b1;
      checks++;
      if (Fetch_PC !== 9'h000 || Halted !== 1'b0) begin
         failures++;
         $display("FAIL reset_release pc=%h halted=%b required pc=000 halted=0", Fetch_PC, Halted);
      end
   endtask

   task automatic test_sequential();
      for (int i = 1; i <= 5; i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b0);
         e = sb.pop_front();
         checks++;
         if (Fetch_PC !== e.pc || Fetch_PC !== 9'(4 * i)) begin
            failures++;
            $display("FAIL seq_pc edge=%0d got=%h required=%h", i, Fetch_PC, e.pc);
         end
         checks++;
         if (IF_Valid !== 1'b1 || IF_PC !== e.if_pc || IF_Instr !== e.if_instr) begin
            failures++;
            $display("FAIL seq_ifid edge=%0d got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                     i, IF_Valid, IF_PC, IF_Instr, e.if_pc, e.if_instr);
         end
      end
   endtask

   task automatic test_wrap();
      drive(1'b0, 1'b1, 32'h0000_01FC, 1'b0);
      e = sb.pop_front();
      checks++;
      if (Fetch_PC !== e.pc) begin
         failures++;
         $display("FAIL wrap_setup got=%h required=%h", Fetch_PC, e.pc);
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (Fetch_PC !== e.pc || IF_PC !== e.if_pc || IF_Valid !== 1'b1) begin
         failures++;
         $display("FAIL wrap got pc=%h if_pc=%h v=%b required pc=%h if_pc=%h v=1",
                  Fetch_PC, IF_PC, IF_Valid, e.pc, e.if_pc);
      end
   endtask

   task automatic test_redirect_stall();
      apply_reset();
      drive(1'b1, 1'b1, 32'h0000_0046, 1'b0);
      e = sb.pop_front();
      checks++;
      if (obs_flush !== e.flush) begin
         failures++;
         $display("FAIL redir_flush got=%b required=%b", obs_flush, e.flush);
      end
      checks++;
      if (Fetch_PC !== e.pc || IF_Valid !== e.if_valid) begin
         failures++;
         $display("FAIL redir_pc got pc=%h v=%b required pc=%h v=%b", Fetch_PC, IF_Valid, e.pc, e.if_valid);
      end
      checks++;
      if (Misalign_Err !== e.mis || Redirect_Cnt !== e.cnt) begin
         failures++;
         $display("FAIL redir_stats got mis=%b cnt=%h required mis=%b cnt=%h",
                  Misalign_Err, Redirect_Cnt, e.mis, e.cnt);
      end
   endtask

   task automatic test_stall();
      logic [8:0]  hold_pc;
      logic [31:0] hold_instr;
      drive(1'b0, 1'b1, 32'h0000_001C, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      void'(sb.pop_front()); void'(sb.pop_front());
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 32'h0, 1'b0);
         e = sb.pop_front();
         checks++;
         if (Fetch_PC !== e.pc || IF_PC !== e.if_pc || IF_Instr !== e.if_instr || IF_Valid !== e.if_valid
             || obs_flush !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold edge=%0d got pc=%h if_pc=%h v=%b required pc=%h if_pc=%h v=%b",
                     i, Fetch_PC, IF_PC, IF_Valid, e.pc, e.if_pc, e.if_valid);
         end
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      e = sb.pop_front();
      hold_pc = e.if_pc; hold_instr = e.if_instr;
      checks++;
      if (Fetch_PC !== e.pc || IF_PC !== hold_pc || IF_Instr !== hold_instr) begin
         failures++;
         $display("FAIL stall_release got pc=%h if_pc=%h required pc=%h if_pc=%h",
                  Fetch_PC, IF_PC, e.pc, hold_pc);
      end
   endtask

   task automatic test_halt();
      logic [15:0] cnt_before;
      drive(1'b0, 1'b1, 32'h0000_002C, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      void'(sb.pop_front()); void'(sb.pop_front());
      cnt_before = m_cnt;
      drive(1'b0, 1'b1, 32'h0000_0080, 1'b1);
      e = sb.pop_front();
      checks++;
      if (Halted !== 1'b1 || Fetch_PC !== e.pc || obs_flush !== e.flush || IF_Valid !== 1'b0) begin
         failures++;
         $display("FAIL halt_enter got halted=%b pc=%h flush=%b v=%b required halted=1 pc=%h flush=%b v=0",
                  Halted, Fetch_PC, obs_flush, IF_Valid, e.pc, e.flush);
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, 1'($urandom_range(1)));
         e = sb.pop_front();
         checks++;
         if (Fetch_PC !== e.pc || IF_Valid !== 1'b0 || obs_flush !== 1'b0 || Halted !== 1'b1
             || Redirect_Cnt !== cnt_before) begin
            failures++;
            $display("FAIL halt_hold edge=%0d got pc=%h v=%b flush=%b halted=%b cnt=%h required pc=%h v=0 flush=0 halted=1 cnt=%h",
                     i, Fetch_PC, IF_Valid, obs_flush, Halted, Redirect_Cnt, e.pc, cnt_before);
         end
      end
      apply_reset();
      checks++;
      if (Fetch_PC !== 9'h000 || Halted !== 1'b0) begin
         failures++;
         $display("FAIL halt_reset got pc=%h halted=%b required pc=000 halted=0", Fetch_PC, Halted);
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (Fetch_PC !== e.pc || IF_Valid !== 1'b1 || IF_PC !== e.if_pc) begin
         failures++;
         $display("FAIL halt_restart got pc=%h v=%b if_pc=%h required pc=%h v=1 if_pc=%h",
                  Fetch_PC, IF_Valid, IF_PC, e.pc, e.if_pc);
      end
   endtask

   task automatic test_saturate();
      apply_reset();
      for (int i = 0; i < 65535; i++) begin
         drive(1'b0, 1'b1, 32'h0000_0100, 1'b0);
         e = sb.pop_front();
      end
      checks++;
      if (Redirect_Cnt !== e.cnt || Redirect_Cnt !== 16'hFFFF || Misalign_Err !== 1'b0) begin
         failures++;
         $display("FAIL sat_reach got cnt=%h mis=%b required cnt=%h mis=0", Redirect_Cnt, Misalign_Err, e.cnt);
      end
      drive(1'b0, 1'b1, 32'h0000_0101, 1'b0);
      e = sb.pop_front();
      checks++;
      if (Redirect_Cnt !== e.cnt || Misalign_Err !== e.mis || Fetch_PC !== e.pc) begin
         failures++;
         $display("FAIL sat_hold got cnt=%h mis=%b pc=%h required cnt=%h mis=%b pc=%h",
                  Redirect_Cnt, Misalign_Err, Fetch_PC, e.cnt, e.mis, e.pc);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_wrap();
      test_redirect_stall();
      test_stall();
      test_halt();
      test_saturate();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
